// File: rtl/cells_bist_pkg.sv
// Shared types and constants for the cell-library logic-BIST wrapper.
package cells_bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_APPLY,
    ST_CAPTURE,
    ST_DONE
  } state_t;

  // Feedback taps x16+x14+x13+x11 expressed as bits 15,13,12,10 of the shift register.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam logic [15:0] LFSR_SEED = 16'h0001;
  localparam logic [31:0] MISR_POLY = 32'h0040_0007;

endpackage

// File: rtl/cells_bist_misr.sv
// Multiple-input signature register; wide responses are XOR-folded down to WIDTH bits first.
module cells_bist_misr
  import cells_bist_pkg::*;
#(
  parameter int unsigned     WIDTH = 32,
  parameter int unsigned     IN_W  = 64,
  parameter logic [WIDTH-1:0] POLY = WIDTH'(MISR_POLY)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic [IN_W-1:0]   resp,
  output logic [WIDTH-1:0]  sig,
  output logic [WIDTH-1:0]  sig_next_c
);

  localparam int unsigned NSLICE = (IN_W + WIDTH - 1) / WIDTH;
  localparam int unsigned PAD_W  = NSLICE * WIDTH;

  logic [PAD_W-1:0] padded;
  logic [WIDTH-1:0] fold;

  // Zero-pad the top slice, then XOR all slices together.
  always_comb begin
    padded = PAD_W'(resp);
    fold   = '0;
    for (int unsigned i = 0; i < NSLICE; i++) begin
      fold = fold ^ padded[i*WIDTH +: WIDTH];
    end
  end

  assign sig_next_c = {sig[WIDTH-2:0], 1'b0} ^ (sig[WIDTH-1] ? POLY : '0) ^ fold;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      sig <= '0;
    end else if (en) begin
      sig <= sig_next_c;
    end
  end

endmodule

// File: rtl/cells_bist_ctrl.sv
// Logic-BIST controller: LFSR pattern source, APPLY/CAPTURE sequencing and MISR signature check.
module cells_bist_ctrl
  import cells_bist_pkg::*;
#(
  parameter int unsigned PAT_W  = 15,
  parameter int unsigned RESP_W = 64,
  parameter int unsigned MISR_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              in_CLK,
  input  logic              in_RST,
  input  logic              in_START,
  input  logic [CNT_W-1:0]  in_NPAT,
  input  logic [15:0]       in_SEED,
  input  logic [MISR_W-1:0] in_GOLDEN,
  input  logic [RESP_W-1:0] in_RESP,
  output logic [PAT_W-1:0]  out_PAT,
  output logic              out_BUSY,
  output logic              out_DONE,
  output logic              out_PASS,
  output logic [MISR_W-1:0] out_SIG
);

  state_t             state;
  logic [15:0]        lfsr;
  logic [CNT_W-1:0]   count;
  logic [15:0]        lfsr_next_c;
  logic [15:0]        seed_c;
  logic               start_ok_c;
  logic               capture_c;
  logic [MISR_W-1:0]  misr_next_c;

  assign start_ok_c  = in_START && ((state == ST_IDLE) || (state == ST_DONE));
  assign capture_c   = (state == ST_CAPTURE);
  assign seed_c      = (in_SEED == 16'h0000) ? LFSR_SEED : in_SEED;
  assign lfsr_next_c = {lfsr[14:0], ^(lfsr & LFSR_TAPS)};

  cells_bist_misr #(
    .WIDTH (MISR_W),
    .IN_W  (RESP_W),
    .POLY  (MISR_W'(MISR_POLY))
  ) u_misr (
    .clk        (in_CLK),
    .rst        (in_RST),
    .clr        (start_ok_c),
    .en         (capture_c),
    .resp       (in_RESP),
    .sig        (out_SIG),
    .sig_next_c (misr_next_c)
  );

  // Sequencer; PASS compares against the MISR value being written on the same edge DONE is entered.
  always_ff @(posedge in_CLK) begin
    if (in_RST) begin
      state    <= ST_IDLE;
      lfsr     <= LFSR_SEED;
      count    <= '0;
      out_PAT  <= '0;
      out_BUSY <= 1'b0;
      out_DONE <= 1'b0;
      out_PASS <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (in_START) begin
            lfsr     <= seed_c;
            count    <= in_NPAT;
            out_DONE <= 1'b0;
            out_PASS <= 1'b0;
            if (in_NPAT == '0) begin
              state    <= ST_DONE;
              out_PAT  <= '0;
              out_DONE <= 1'b1;
              out_PASS <= (in_GOLDEN == '0);
            end else begin
              state    <= ST_APPLY;
              out_PAT  <= seed_c[PAT_W-1:0];
              out_BUSY <= 1'b1;
            end
          end
        end
        ST_APPLY: begin
          state <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          lfsr  <= lfsr_next_c;
          count <= count - CNT_W'(1);
          if (count == CNT_W'(1)) begin
            state    <= ST_DONE;
            out_BUSY <= 1'b0;
            out_DONE <= 1'b1;
            out_PASS <= (misr_next_c == in_GOLDEN);
          end else begin
            state   <= ST_APPLY;
            out_PAT <= lfsr_next_c[PAT_W-1:0];
          end
        end
        default: begin
          state    <= ST_IDLE;
          out_BUSY <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cells_bist_ctrl.sv
// Bench for cells_bist_ctrl: run-level schedule model, per-cycle compare, directed pins and random runs.
module tb_cells_bist_ctrl;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [15:0] npat, seed;
  logic [31:0] golden;
  logic [63:0] resp;
  logic [14:0] pat;
  logic        busy, done, pass;
  logic [31:0] sig;

  logic        use_const, fault, check_en;
  logic [63:0] resp_const, mask;
  int          checks = 0;
  int          errors = 0;

  typedef struct packed {
    logic        busy;
    logic        done;
    logic        pass;
    logic [14:0] pat;
    logic [31:0] sig;
  } exp_t;

  exp_t        sched[$];
  exp_t        cur;
  logic [14:0] exp_p [6];

  always #5 clk = ~clk;

  cells_bist_ctrl dut (
    .in_CLK    (clk),
    .in_RST    (rst),
    .in_START  (start),
    .in_NPAT   (npat),
    .in_SEED   (seed),
    .in_GOLDEN (golden),
    .in_RESP   (resp),
    .out_PAT   (pat),
    .out_BUSY  (busy),
    .out_DONE  (done),
    .out_PASS  (pass),
    .out_SIG   (sig)
  );

  // Small stand-in for the SAED90 cell netlist; bit 5 is the XOR2X1 output.
  function automatic logic [63:0] cells(input logic [14:0] p, input logic sa);
    logic inp, in1, in2, in3, in4, in5, in6, s, s0, s1, a, b, ci, a0, b0;
    logic [3:0]  v;
    logic [63:0] o;
    {b0, a0, ci, b, a, s1, s0, s, in6, in5, in4, in3, in2, in1, inp} = p;
    v = {in4, in3, in2, in1};
    o = '0;
    o[0]     = ~inp;
    o[1]     = in1 & in2;
    o[2]     = in3 | in4;
    o[3]     = ~(in1 & in2 & in3);
    o[4]     = ~(in5 | in6);
    o[5]     = sa ? 1'b0 : (in5 ^ in6);
    o[6]     = ~(in1 ^ in4);
    o[7]     = s ? in2 : in1;
    o[8]     = v[{s1, s0}];
    o[10:9]  = {1'b0, a} + {1'b0, b} + {1'b0, ci};
    o[12:11] = {1'b0, a0} + {1'b0, b0};
    o[13]    = (in1 & in2) | (in3 & in4);
    o[14]    = (in5 | in6) & s;
    return o;
  endfunction

  function automatic logic [63:0] resp_fn(input logic [14:0] p, input logic uc,
                                          input logic [63:0] rc, input logic sa,
                                          input logic [63:0] m);
    return uc ? rc : (cells(p, sa) ^ m);
  endfunction

  assign resp = resp_fn(pat, use_const, resp_const, fault, mask);

  function automatic logic [15:0] lfsr_step(input logic [15:0] x);
    int fb;
    fb = $countones(x & 16'hB400) % 2;
    return 16'((x << 1) | 16'(fb));
  endfunction

  function automatic logic [31:0] misr_step(input logic [31:0] s, input logic [63:0] r);
    logic [31:0] f;
    f = r[31:0] ^ r[63:32];
    return 32'(s << 1) ^ (s[31] ? 32'h0040_0007 : 32'h0) ^ f;
  endfunction

  function automatic logic [31:0] final_sig(input logic [15:0] s, input logic [15:0] n);
    logic [15:0] l;
    logic [31:0] acc;
    l   = (s == 16'h0) ? 16'h0001 : s;
    acc = '0;
    for (int i = 0; i < int'(n); i++) begin
      acc = misr_step(acc, resp_fn(l[14:0], use_const, resp_const, fault, mask));
      l   = lfsr_step(l);
    end
    return acc;
  endfunction

  // Expand one accepted start into the full cycle-by-cycle expectation list.
  task automatic plan_run();
    logic [15:0] l;
    logic [31:0] acc;
    logic [14:0] p;
    l   = (seed == 16'h0) ? 16'h0001 : seed;
    acc = '0;
    p   = '0;
    for (int i = 0; i < int'(npat); i++) begin
      p = l[14:0];
      sched.push_back(exp_t'{1'b1, 1'b0, 1'b0, p, acc});
      sched.push_back(exp_t'{1'b1, 1'b0, 1'b0, p, acc});
      acc = misr_step(acc, resp_fn(p, use_const, resp_const, fault, mask));
      l   = lfsr_step(l);
    end
    sched.push_back(exp_t'{1'b0, 1'b1, 1'b0, p, acc});
  endtask

  always @(posedge clk) begin : model
    exp_t nx;
    nx = cur;
    if (rst) begin
      sched.delete();
      nx = '0;
    end else begin
      if (sched.size() == 0 && start) plan_run();
      if (sched.size() != 0) begin
        nx = sched.pop_front();
        if (nx.done) nx.pass = (nx.sig == golden);
      end
    end
    cur <= nx;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      chk("busy", 64'(busy), 64'(cur.busy));
      chk("done", 64'(done), 64'(cur.done));
      chk("pass", 64'(pass), 64'(cur.pass));
      chk("pat",  64'(pat),  64'(cur.pat));
      chk("sig",  64'(sig),  64'(cur.sig));
    end
  end

  task automatic pin(input string name, input logic [63:0] dut_v,
                     input logic [63:0] mdl_v, input logic [63:0] lit);
    chk({name, "_dut"}, dut_v, lit);
    chk({name, "_model"}, mdl_v, lit);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_run(input logic [15:0] s, input logic [15:0] n,
                           input logic [31:0] g, input int hold);
    seed   = s;
    npat   = n;
    golden = g;
    start  = 1'b1;
    tick(hold);
    start  = 1'b0;
  endtask

  task automatic wait_done(input int maxc);
    int k;
    k = 0;
    while (!done && k < maxc) begin
      @(negedge clk);
      k++;
    end
    chk("done_timeout", 64'(done), 64'(1));
  endtask

  initial begin
    logic [31:0] g;
    logic [15:0] s, n;
    exp_p = '{15'h0001, 15'h0001, 15'h0002, 15'h0002, 15'h0004, 15'h0004};
    rst = 1'b1; start = 1'b0; npat = '0; seed = '0; golden = '0;
    use_const = 1'b1; resp_const = '0; fault = 1'b0; mask = '0; check_en = 1'b0;
    tick(2);
    check_en = 1'b1;
    pin("rst_busy", 64'(busy), 64'(cur.busy), 64'(0));
    pin("rst_done", 64'(done), 64'(cur.done), 64'(0));
    pin("rst_pat",  64'(pat),  64'(cur.pat),  64'(0));
    pin("rst_sig",  64'(sig),  64'(cur.sig),  64'(0));
    rst = 1'b0;
    tick(1);

    // NPAT=0 goes straight to DONE
    start_run(16'h0001, 16'd0, 32'h0, 1);
    pin("n0_done", 64'(done), 64'(cur.done), 64'(1));
    pin("n0_pass", 64'(pass), 64'(cur.pass), 64'(1));
    pin("n0_busy", 64'(busy), 64'(cur.busy), 64'(0));
    tick(1);

    // Three patterns of zero response: 1,2,4 each held two cycles
    start_run(16'h0001, 16'd3, 32'h0, 1);
    for (int i = 0; i < 6; i++) begin
      pin("n3_pat", 64'(pat), 64'(cur.pat), 64'(exp_p[i]));
      tick(1);
    end
    pin("n3_done", 64'(done), 64'(cur.done), 64'(1));
    pin("n3_pass", 64'(pass), 64'(cur.pass), 64'(1));
    pin("n3_sig",  64'(sig),  64'(cur.sig),  64'(0));

    // Single-pattern signature and golden compare
    resp_const = 64'h1;
    start_run(16'h0001, 16'd1, 32'h1, 1);
    tick(2);
    pin("r1_sig",  64'(sig),  64'(cur.sig),  64'(1));
    pin("r1_pass", 64'(pass), 64'(cur.pass), 64'(1));
    start_run(16'h0001, 16'd1, 32'h2, 1);
    tick(2);
    pin("r1_fail", 64'(pass), 64'(cur.pass), 64'(0));
    resp_const = 64'h1_0000_0001;
    start_run(16'h0001, 16'd1, 32'h0, 1);
    tick(2);
    pin("fold_sig",  64'(sig),  64'(cur.sig),  64'(0));
    pin("fold_pass", 64'(pass), 64'(cur.pass), 64'(1));
    golden = 32'h5;
    tick(2);
    pin("gold_late", 64'(pass), 64'(cur.pass), 64'(1));

    // Seed 0 behaves like seed 1
    resp_const = 64'h0;
    start_run(16'h0000, 16'd2, 32'h0, 1);
    pin("seed0_pat", 64'(pat), 64'(cur.pat), 64'(1));
    wait_done(10);
    tick(1);

    // Reset during second CAPTURE with START held throughout
    seed = 16'hACE1; npat = 16'd5; golden = '0; start = 1'b1;
    tick(4);
    pin("mid_busy", 64'(busy), 64'(cur.busy), 64'(1));
    rst = 1'b1; start = 1'b0;
    tick(1);
    pin("abort_busy", 64'(busy), 64'(cur.busy), 64'(0));
    pin("abort_done", 64'(done), 64'(cur.done), 64'(0));
    pin("abort_pat",  64'(pat),  64'(cur.pat),  64'(0));
    pin("abort_sig",  64'(sig),  64'(cur.sig),  64'(0));
    rst = 1'b0;
    tick(1);

    // Closed loop with the cell model, then a stuck-at on XOR2X1
    use_const = 1'b0; fault = 1'b0; mask = '0;
    g = final_sig(16'h1234, 16'd1000);
    start_run(16'h1234, 16'd1000, g, 1);
    wait_done(2100);
    pin("loop_pass", 64'(pass), 64'(cur.pass), 64'(1));
    chk("loop_sig", 64'(sig), 64'(g));
    fault = 1'b1;
    start_run(16'h1234, 16'd1000, g, 1);
    wait_done(2100);
    pin("stuck_pass", 64'(pass), 64'(cur.pass), 64'(0));
    tick(1);

    // Random runs, including held starts, late golden changes and aborts
    for (int r = 0; r < 16; r++) begin
      fault = ($urandom_range(0, 3) == 0);
      mask  = {$urandom, $urandom};
      s     = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
      n     = 16'($urandom_range(0, 12));
      g     = ($urandom_range(0, 1) == 1) ? final_sig(s, n) : $urandom;
      start_run(s, n, g, int'($urandom_range(1, 3)));
      if ($urandom_range(0, 4) == 0 && n > 16'd2) begin
        tick(2);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
      end else begin
        wait_done(2 * int'(n) + 8);
        golden = $urandom;
        tick(int'($urandom_range(1, 3)));
      end
    end

    tick(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cells_bist_ctrl.md
Name: cells_bist_ctrl

Overview:
Logic-BIST wrapper stage around the SAED90 cell-library test netlist. It sits directly upstream and downstream of that combinational block:
- Upstream, an LFSR drives the 15 primary inputs (INP, IN1..IN6, S, S0, S1, A, B, CI, A0, B0).
- Downstream, a MISR compacts the cell outputs into a signature and compares it against a golden value.
- The sequencing FSM lets the netlist settle for one cycle before each capture.

Parameters:
- PAT_W, 15, pattern width driven to the cell netlist (LFSR low bits).
- RESP_W, 64, response width; the instantiating wrapper concatenates the cell outputs and zero-pads them.
- MISR_W, 32, signature width.
- CNT_W, 16, pattern-count width.

Ports:
- in_CLK  input  1  clock; all state updates on the rising edge.
- in_RST  input  1  synchronous, active-high reset.
- in_START  input  1  start-run pulse; sampled only in IDLE or DONE.
- in_NPAT  input  CNT_W  number of patterns to apply; sampled on start.
- in_SEED  input  16  LFSR seed; sampled on start.
- in_GOLDEN  input  MISR_W  expected signature; compared at end of run.
- in_RESP  input  RESP_W  cell-netlist responses for the current out_PAT.
- out_PAT  output  PAT_W  pattern applied to the cell netlist.
- out_BUSY  output  1  run in progress (APPLY or CAPTURE).
- out_DONE  output  1  run complete; held until next start or reset.
- out_PASS  output  1  signature equals golden; valid only while out_DONE=1.
- out_SIG  output  MISR_W  current MISR contents.

Behaviour:
- Reset: state=IDLE, LFSR=16'h0001, MISR=0, count=0. All outputs are 0, including out_PAT=0. Reset asserted mid-run aborts the run to IDLE in the same edge; no partial DONE is produced.
- FSM states: IDLE, APPLY, CAPTURE, DONE.
- IDLE or DONE with in_START=1:
  - Load LFSR with in_SEED. A seed of 0 is replaced by 16'h0001.
  - Clear MISR; load count with in_NPAT.
  - Clear out_DONE and out_PASS.
  - Go to APPLY, or directly to DONE if in_NPAT=0.
- APPLY, 1 cycle: out_PAT = LFSR[PAT_W-1:0]; the netlist settles. Go to CAPTURE.
- CAPTURE, 1 cycle: out_PAT is unchanged. At the end of the cycle:
  - MISR <= {MISR[MISR_W-2:0],0} ^ (MISR[MISR_W-1] ? 32'h0040_0007 : 0) ^ fold(in_RESP), where fold = XOR of the MISR_W-bit slices of in_RESP, with the last slice zero-padded.
  - LFSR <= {LFSR[14:0], LFSR[15]^LFSR[13]^LFSR[12]^LFSR[10]}.
  - count <= count-1.
  - Next state is DONE if count==1, else APPLY.
- Per-pattern cost is 2 cycles. Total run = 2*NPAT cycles from the first APPLY to DONE.
- DONE:
  - out_DONE=1 and out_PASS=(MISR==in_GOLDEN), both registered on entry.
  - out_BUSY=0. out_PAT holds its last value (0 if NPAT=0).
- out_BUSY=1 exactly in APPLY and CAPTURE. in_START is ignored while busy.
- in_START in DONE restarts with a fresh seed and count. The LFSR does not continue from the previous run.
- in_GOLDEN is compared only on DONE entry. Later changes to it do not alter out_PASS.
- out_SIG continuously reflects the MISR register.

Decomposition:
- Package cells_bist_pkg holds:
  - the FSM state enum;
  - LFSR taps constant and default seed 16'h0001;
  - MISR polynomial constant 32'h0040_0007.
- One natural sub-module, cells_bist_misr (parameterised MISR with fold), reusable for other cell-netlist testbenches.
- The LFSR and FSM stay inline.

Test Plan:
- Reset then in_START with NPAT=0, GOLDEN=0 -> out_DONE=1 on the 2nd cycle after start; out_PASS=1, out_SIG=0, out_BUSY never asserted.
- SEED=0x0001, NPAT=3, in_RESP=0 -> out_PAT=0x0001, 0x0002, 0x0004 (each held 2 cycles); DONE after 6 cycles, SIG=0, PASS=1 with GOLDEN=0.
- SEED=0x0001, NPAT=1, in_RESP=64'h1 -> SIG=32'h0000_0001, PASS=1 with GOLDEN=1 and PASS=0 with GOLDEN=2. Also in_RESP=64'h1_0000_0001 -> fold=0, SIG=0.
- SEED=0 -> behaves identically to SEED=0x0001 (first out_PAT=0x0001).
- in_RST pulsed during the 2nd CAPTURE of an NPAT=5 run -> next cycle IDLE, out_PAT=0, out_SIG=0, out_BUSY=0, out_DONE=0. An in_START held during the run is ignored until DONE or IDLE.
- Full loop with the SAED90 netlist model on RESP_W=64: NPAT=1000 gives a signature matching the bench reference model, and a single injected stuck-at on out_XOR2X1 flips PASS to 0.
